output_controller: RTL and testbench
====================================

# output_controller

Memory-mapped output port on the processor data bus, the display-bound counterpart of the input controller. The processor stores game state (sprite positions, score, game state) into a shadow register bank. On each rising edge of the game frame-rate clock, the block copies the shadow bank into an active bank that drives the display logic, so the display never sees a half-updated frame. It also exposes a frame counter and a control register, so software can pace itself to frames.

## Interface

- ADDR_WIDTH, 12, width of processor data address
- BASE_ADDR, 12'hF00, first word address of the I/O window
- NUM_REGS, 8, number of 32-bit display data registers (1..64)

- proc_clk  in  1  processor clock; all state is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_rt_clk  in  1  frame-rate clock (e.g. 60 Hz), asynchronous to proc_clk
- wren  in  1  processor store strobe
- address  in  ADDR_WIDTH  processor data word address
- data  in  32  processor store data
- q_io  out  32  registered read data for the window
- io_hit  out  1  registered; the previous cycle's address was inside the window
- disp_regs  out  NUM_REGS*32  active bank, flattened; reg i at [32*i+31:32*i]
- frame_tick  out  1  one-cycle pulse in the cycle after a frame commit
- frame_count  out  32  number of frames elapsed since reset

## Operation

- Window: offset = address - BASE_ADDR. The address is in the window when 0 <= offset < NUM_REGS+2. Unsigned compare; an address below BASE_ADDR is outside.
- Offsets 0..NUM_REGS-1 are the shadow data registers, R/W. A read returns the shadow value.
- Offset NUM_REGS is FRAME_COUNT, read-only. Writes to it are ignored.
- Offset NUM_REGS+1 is CTRL. Bit0 is freeze, R/W. A read returns {31'b0, freeze}.
- Writes: when wren=1 and the address is in the window, the target register updates on that edge. Writes outside the window are ignored.
- Reads:
  - q_io and io_hit are registered from address every cycle, independent of wren.
  - If the address is outside the window: q_io=0, io_hit=0.
  - A read and write to the same register in the same cycle returns the old value (read-before-write).
- Frame synchronizer:
  - frame_rt_clk passes through flops s1 then s2, then a history flop s3.
  - tick_cond = s2 & ~s3 & armed.
  - armed resets to 0 and sets on the first cycle in which s2=0. This prevents a spurious tick when frame_rt_clk is high at reset release.
- Commit, on an edge where tick_cond=1:
  - frame_count increments, wrapping 32'hFFFF_FFFF to 0.
  - frame_tick is asserted for the following cycle.
  - If freeze=0, the active bank is loaded from the shadow bank. A shadow write on the same edge is merged into the commit, so the new value appears in disp_regs.
  - If freeze=1, the active bank holds. The counter and tick still occur.
- A write to CTRL on a commit edge does not affect that commit; the old freeze value governs it.
- The active bank changes only on a commit edge.

## Timing

- Reset (asynchronous, reset_n=0): all of the following are 0 immediately and held while reset_n=0:
  - shadow bank, active bank, disp_regs
  - freeze, frame_count, frame_tick
  - q_io, io_hit
  - s1, s2, s3, armed
- Write latency: shadow is updated at the edge where wren is sampled. A read issued the next cycle sees the new value.
- Read latency: 1 cycle. Address presented in cycle n gives q_io/io_hit valid in cycle n+1.
- Frame latency: frame_rt_clk rises and is captured by s1 at edge k. tick_cond is high between edges k+1 and k+2. The commit happens at edge k+2, and frame_tick is high from k+2 to k+3.
- frame_rt_clk high for many cycles gives exactly one commit per rising edge.
- Reset asserted mid-frame or mid-write: the in-flight write is lost, and no commit occurs until armed is set and a fresh rising edge arrives.

## Test plan

- Reset values: hold reset_n=0 with frame_rt_clk=1, then release.
  - Immediately after release: disp_regs=0, frame_count=0, q_io=0.
  - No frame_tick until frame_rt_clk goes low and then high again.
- Write/read: write 32'hDEAD_BEEF to F00 and 32'h1234 to F07. Read F00, F07 and F0A.
  - One cycle after each read: q_io=DEAD_BEEF/io_hit=1, 1234/1, then 0/0.
  - disp_regs is unchanged until the next commit.
- Commit: toggle frame_rt_clk 0→1.
  - disp_regs[31:0]=DEAD_BEEF and [255:224]=1234 exactly 2 cycles after capture.
  - frame_tick pulses for one cycle; frame_count=1.
- Simultaneous write and commit: write F03=32'h55 on the commit edge.
  - disp_regs[127:96]=55.
  - A same-cycle read of F03 returns the old value.
- Freeze: write F09=1, change F01=7, then pulse the frame clock.
  - disp_regs[63:32] is unchanged; frame_count increments.
  - Write F09=0 and pulse again: disp_regs[63:32]=7.
- Wrap and read-only: force 2^32-1 frames (or preload via a bench hierarchical deposit), then one more pulse → frame_count=0. Writing F08 does not change frame_count.

Source files
------------

// File: rtl/output_controller.sv
// Memory-mapped display output port: the processor fills a shadow bank, and each
// synchronized rising edge of the frame-rate clock commits it to the active bank.
module output_controller #(
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 12'hF00,
    parameter int unsigned           NUM_REGS   = 8
) (
    input  logic                   proc_clk,
    input  logic                   reset_n,
    input  logic                   frame_rt_clk,
    input  logic                   wren,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic [31:0]            data,
    output logic [31:0]            q_io,
    output logic                   io_hit,
    output logic [NUM_REGS*32-1:0] disp_regs,
    output logic                   frame_tick,
    output logic [31:0]            frame_count
);
    localparam logic [ADDR_WIDTH-1:0] CNT_OFF  = ADDR_WIDTH'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] CTRL_OFF = ADDR_WIDTH'(NUM_REGS + 1);

    logic [31:0]           shadow_q [NUM_REGS];
    logic [31:0]           shadow_d [NUM_REGS];
    logic [31:0]           active_q [NUM_REGS];
    logic [31:0]           frame_count_q;
    logic                  freeze_q;
    logic                  freeze_d;
    logic                  frame_tick_q;
    logic [31:0]           q_io_q;
    logic                  io_hit_q;
    logic                  s1_q;
    logic                  s2_q;
    logic                  s3_q;
    logic                  armed_q;
    logic [1:0]            fill_q;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_win;
    logic [31:0]           rd_val;
    logic                  tick_cond;

    assign offset    = address - BASE_ADDR;
    assign in_win    = (address >= BASE_ADDR) && (offset <= CTRL_OFF);
    assign tick_cond = s2_q & ~s3_q & armed_q;

    // Read mux sees pre-write values; shadow_d carries this cycle's store so a
    // commit on the same edge picks it up.
    always_comb begin
        shadow_d = shadow_q;
        freeze_d = freeze_q;
        rd_val   = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (offset == ADDR_WIDTH'(i)) begin
                rd_val = shadow_q[i];
                if (wren && in_win) begin
                    shadow_d[i] = data;
                end
            end
        end
        if (offset == CNT_OFF) begin
            rd_val = frame_count_q;
        end
        if (offset == CTRL_OFF) begin
            rd_val = {31'b0, freeze_q};
            if (wren && in_win) begin
                freeze_d = data[0];
            end
        end
    end

    always_ff @(posedge proc_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            frame_count_q <= '0;
            freeze_q      <= 1'b0;
            frame_tick_q  <= 1'b0;
            q_io_q        <= '0;
            io_hit_q      <= 1'b0;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            armed_q       <= 1'b0;
            fill_q        <= '0;
        end else begin
            shadow_q     <= shadow_d;
            freeze_q     <= freeze_d;
            q_io_q       <= in_win ? rd_val : 32'd0;
            io_hit_q     <= in_win;
            s1_q         <= frame_rt_clk;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            fill_q       <= {fill_q[0], 1'b1};
            // The reset zeros in s1/s2 are not real samples, so arming waits
            // until s2 holds an observed low level of the frame clock.
            if (fill_q[1] && !s2_q) begin
                armed_q <= 1'b1;
            end
            frame_tick_q <= tick_cond;
            if (tick_cond) begin
                frame_count_q <= frame_count_q + 32'd1;
                if (!freeze_q) begin
                    active_q <= shadow_d;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_disp
        assign disp_regs[32*g +: 32] = active_q[g];
    end

    assign q_io        = q_io_q;
    assign io_hit      = io_hit_q;
    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_output_controller.sv
// Self-checking bench for output_controller: bus reads are scored through an
// expected queue, frame commits against a small shadow/active bank model.
module tb_output_controller;
    localparam int          AW   = 12;
    localparam int          NR   = 8;
    localparam logic [11:0] BASE = 12'hF00;

    logic               proc_clk     = 1'b0;
    logic               reset_n      = 1'b1;
    logic               frame_rt_clk = 1'b1;
    logic               wren         = 1'b0;
    logic [11:0]        address      = '0;
    logic [31:0]        data         = '0;
    logic [31:0]        q_io;
    logic               io_hit;
    logic [NR*32-1:0]   disp_regs;
    logic               frame_tick;
    logic [31:0]        frame_count;

    output_controller #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .NUM_REGS  (NR)
    ) dut (
        .proc_clk    (proc_clk),
        .reset_n     (reset_n),
        .frame_rt_clk(frame_rt_clk),
        .wren        (wren),
        .address     (address),
        .data        (data),
        .q_io        (q_io),
        .io_hit      (io_hit),
        .disp_regs   (disp_regs),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    // ---------------- clock / reset ----------------
    always #5 proc_clk = ~proc_clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          tick_cnt = 0;
    int          ticks_m  = 0;
    logic [32:0] exp_q[$];
    logic [31:0] shadow_m [NR];
    logic [31:0] active_m [NR];
    logic [31:0] fcnt_m;
    logic        freeze_m;

    always @(negedge proc_clk) begin
        if (frame_tick) tick_cnt++;
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        fcnt_m   = '0;
        freeze_m = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [32:0] model_read(input logic [11:0] a);
        logic [11:0] off;
        off = a - BASE;
        if (a < BASE || off >= 12'(NR + 2)) return 33'd0;
        if (off < 12'(NR)) return {1'b1, shadow_m[off[2:0]]};
        if (off == 12'(NR)) return {1'b1, fcnt_m};
        return {1'b1, 31'd0, freeze_m};
    endfunction

    task automatic model_write(input logic w, input logic [11:0] a, input logic [31:0] d);
        logic [11:0] off;
        off = a - BASE;
        if (w && a >= BASE && off < 12'(NR)) shadow_m[off[2:0]] = d;
        else if (w && a >= BASE && off == 12'(NR + 1)) freeze_m = d[0];
    endtask

    function automatic logic [255:0] flat_active();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[32*i +: 32] = active_m[i];
        return r;
    endfunction

    task automatic model_commit();
        fcnt_m = fcnt_m + 32'd1;
        ticks_m++;
        if (!freeze_m) begin
            for (int i = 0; i < NR; i++) active_m[i] = shadow_m[i];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge proc_clk);
        #1;
    endtask

    task automatic bus_cycle(input logic w, input logic [11:0] a, input logic [31:0] d, input string tag);
        logic [32:0] e;
        wren    = w;
        address = a;
        data    = d;
        exp_q.push_back(model_read(a));
        model_write(w, a, d);
        step();
        wren = 1'b0;
        e = exp_q.pop_front();
        check_val({tag, ".q_io"}, 256'(q_io), 256'(e[31:0]));
        check_val({tag, ".io_hit"}, 256'(io_hit), 256'(e[32]));
    endtask

    // Low phase long enough to arm, then a rising edge; the optional access
    // lands on the commit edge (k+2).
    task automatic frame_pulse(input string tag, input logic cw, input logic [11:0] ca, input logic [31:0] cd);
        frame_rt_clk = 1'b0;
        repeat (4) bus_cycle(1'b0, 12'h000, 32'd0, {tag, ".low"});
        frame_rt_clk = 1'b1;
        bus_cycle(1'b0, 12'h000, 32'd0, {tag, ".k"});
        bus_cycle(1'b0, 12'h000, 32'd0, {tag, ".k1"});
        check_val({tag, ".disp_pre"}, 256'(disp_regs), flat_active());
        check_val({tag, ".tick_pre"}, 256'(frame_tick), 256'(0));
        bus_cycle(cw, ca, cd, {tag, ".k2"});
        model_commit();
        check_val({tag, ".disp"}, 256'(disp_regs), flat_active());
        check_val({tag, ".tick"}, 256'(frame_tick), 256'(1));
        check_val({tag, ".count"}, 256'(frame_count), 256'(fcnt_m));
        bus_cycle(1'b0, 12'h000, 32'd0, {tag, ".k3"});
        check_val({tag, ".tick_end"}, 256'(frame_tick), 256'(0));
        check_val({tag, ".tick_total"}, 256'(tick_cnt), 256'(ticks_m));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        model_clear();

        // Reset with frame clock held high.
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_async.disp", 256'(disp_regs), 256'(0));
        check_val("rst_async.count", 256'(frame_count), 256'(0));
        repeat (3) step();
        reset_n = 1'b1;
        check_val("rst.disp", 256'(disp_regs), 256'(0));
        check_val("rst.count", 256'(frame_count), 256'(0));
        check_val("rst.q_io", 256'(q_io), 256'(0));
        check_val("rst.io_hit", 256'(io_hit), 256'(0));
        check_val("rst.tick", 256'(frame_tick), 256'(0));
        repeat (10) bus_cycle(1'b0, 12'h000, 32'd0, "rst_idle");
        check_val("rst.no_spurious_tick", 256'(tick_cnt), 256'(0));

        // Writes and reads, including window edges.
        bus_cycle(1'b1, 12'hF00, 32'hDEAD_BEEF, "wr_f00");
        bus_cycle(1'b1, 12'hF07, 32'h0000_1234, "wr_f07");
        bus_cycle(1'b0, 12'hF00, 32'd0, "rd_f00");
        check_val("rd_f00.const", 256'(q_io), 256'(32'hDEAD_BEEF));
        bus_cycle(1'b0, 12'hF07, 32'd0, "rd_f07");
        check_val("rd_f07.const", 256'(q_io), 256'(32'h1234));
        bus_cycle(1'b0, 12'hF0A, 32'd0, "rd_f0a");
        check_val("rd_f0a.hit", 256'(io_hit), 256'(0));
        bus_cycle(1'b0, 12'hEFF, 32'd0, "rd_below");
        bus_cycle(1'b0, 12'hF08, 32'd0, "rd_count");
        bus_cycle(1'b0, 12'hF09, 32'd0, "rd_ctrl");
        check_val("wr.disp_unchanged", 256'(disp_regs), 256'(0));

        // First commit.
        frame_pulse("c1", 1'b0, 12'h000, 32'd0);
        check_val("c1.disp0", 256'(disp_regs[31:0]), 256'(32'hDEAD_BEEF));
        check_val("c1.disp7", 256'(disp_regs[255:224]), 256'(32'h1234));
        check_val("c1.count", 256'(frame_count), 256'(1));
        repeat (10) bus_cycle(1'b0, 12'h000, 32'd0, "c1_hold");
        check_val("c1.one_tick", 256'(tick_cnt), 256'(1));

        // Write on the commit edge merges; same-cycle read returns old value.
        frame_pulse("c2", 1'b1, 12'hF03, 32'h55);
        check_val("c2.disp3", 256'(disp_regs[127:96]), 256'(32'h55));
        bus_cycle(1'b0, 12'hF03, 32'd0, "c2_rd_f03");

        // Freeze holds the active bank but counts the frame.
        bus_cycle(1'b1, 12'hF09, 32'd1, "frz_on");
        bus_cycle(1'b1, 12'hF01, 32'd7, "frz_wr_f01");
        bus_cycle(1'b0, 12'hF09, 32'd0, "frz_rd_ctrl");
        frame_pulse("frz", 1'b0, 12'h000, 32'd0);
        check_val("frz.disp1", 256'(disp_regs[63:32]), 256'(0));
        check_val("frz.count", 256'(frame_count), 256'(3));
        bus_cycle(1'b1, 12'hF09, 32'd0, "frz_off");
        frame_pulse("unfrz", 1'b0, 12'h000, 32'd0);
        check_val("unfrz.disp1", 256'(disp_regs[63:32]), 256'(7));
        check_val("unfrz.count", 256'(frame_count), 256'(4));

        // Random fill of every shadow register.
        for (int i = 0; i < NR; i++)
            bus_cycle(1'b1, BASE + 12'(i), 32'($urandom_range(32'hFFFF_FFFF, 0)), "rnd_wr");
        for (int i = 0; i < NR; i++)
            bus_cycle(1'b0, BASE + 12'(i), 32'd0, "rnd_rd");
        frame_pulse("rnd", 1'b0, 12'h000, 32'd0);

        // Counter wrap and read-only frame count.
        dut.frame_count_q = 32'hFFFF_FFFF;
        fcnt_m = 32'hFFFF_FFFF;
        bus_cycle(1'b0, 12'hF08, 32'd0, "wrap_rd_pre");
        frame_pulse("wrap", 1'b0, 12'h000, 32'd0);
        check_val("wrap.count", 256'(frame_count), 256'(0));
        bus_cycle(1'b1, 12'hF08, 32'h1234, "ro_wr_f08");
        check_val("ro.count", 256'(frame_count), 256'(0));
        bus_cycle(1'b0, 12'hF08, 32'd0, "ro_rd_f08");

        // Reset in the middle of a write; frame clock is high at release.
        wren    = 1'b1;
        address = 12'hF02;
        data    = 32'hAA;
        #2 reset_n = 1'b0;
        #1;
        wren = 1'b0;
        check_val("rst2.disp", 256'(disp_regs), 256'(0));
        check_val("rst2.q_io", 256'(q_io), 256'(0));
        repeat (2) step();
        reset_n = 1'b1;
        model_clear();
        bus_cycle(1'b0, 12'hF02, 32'd0, "rst2_rd_f02");
        check_val("rst2.count", 256'(frame_count), 256'(0));
        repeat (10) bus_cycle(1'b0, 12'h000, 32'd0, "rst2_hold");
        check_val("rst2.no_tick", 256'(tick_cnt), 256'(ticks_m));
        bus_cycle(1'b1, 12'hF05, 32'hCAFE_F00D, "rst2_wr_f05");
        frame_pulse("rearm", 1'b0, 12'h000, 32'd0);
        check_val("rearm.disp5", 256'(disp_regs[191:160]), 256'(32'hCAFE_F00D));

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
